// File: rtl/rt_pkg.sv
// Shared ray-tracing types and fixed-point defaults, also used by ray_box_unit.
package rt_pkg;

  localparam int unsigned RT_FP_W    = 32;
  localparam int unsigned RT_FP_FRAC = 16;

  typedef struct packed {
    logic [RT_FP_W-1:0] x;
    logic [RT_FP_W-1:0] y;
    logic [RT_FP_W-1:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t              origin;
    vec3_t              dir;
    vec3_t              inv_dir;
    logic [RT_FP_W-1:0] t_min;
    logic [RT_FP_W-1:0] t_max;
  } ray_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } aabb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FIN,
    ST_OUT
  } setup_state_e;

  // Component select; any index above 1 maps to z.
  function automatic logic [RT_FP_W-1:0] vec_comp(input vec3_t v, input logic [1:0] idx);
    case (idx)
      2'd0:    vec_comp = v.x;
      2'd1:    vec_comp = v.y;
      default: vec_comp = v.z;
    endcase
  endfunction

  // Component replace; any index above 1 maps to z.
  function automatic vec3_t vec_set(input vec3_t v, input logic [1:0] idx,
                                    input logic [RT_FP_W-1:0] val);
    vec_set = v;
    case (idx)
      2'd0:    vec_set.x = val;
      2'd1:    vec_set.y = val;
      default: vec_set.z = val;
    endcase
  endfunction

  // Magnitude as unsigned; the most negative value maps onto itself (2^(W-1)).
  function automatic logic [RT_FP_W-1:0] abs_u(input logic [RT_FP_W-1:0] d);
    abs_u = d[RT_FP_W-1] ? -d : d;
  endfunction

endpackage

// File: rtl/fxp_recip_div.sv
// Serial unsigned restoring divider: quot = floor(2^(2*FP_FRAC) / divisor),
// one quotient bit per cycle over FP_W+1 cycles. done_c marks the final step.
module fxp_recip_div
  import rt_pkg::*;
#(
  parameter int unsigned FP_W    = RT_FP_W,
  parameter int unsigned FP_FRAC = RT_FP_FRAC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [FP_W-1:0] divisor,
  output logic            busy,
  output logic            done_c,
  output logic [FP_W:0]   quot
);

  localparam int unsigned QW = FP_W + 1;
  localparam int unsigned CW = $clog2(QW + 1);
  localparam logic [QW-1:0] DIVIDEND = QW'(1) << (2 * FP_FRAC);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0] rem_q, rem_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [FP_W-1:0] dsr_q, dsr_d;
  logic [QW-1:0] rem_sh;
  logic          fits;

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      quot_q <= quot_d;
      dsr_q  <= dsr_d;
    end
  end

  // Load on start, otherwise one shift-compare-subtract step per busy cycle.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    quot_d = quot_q;
    dsr_d  = dsr_q;
    rem_sh = {rem_q, dvd_q[QW-1]};
    fits   = (rem_sh >= {1'b0, dsr_q});
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(QW);
      rem_d  = '0;
      dvd_d  = DIVIDEND;
      quot_d = '0;
      dsr_d  = divisor;
    end else if (busy_q) begin
      rem_d  = fits ? FP_W'(rem_sh - {1'b0, dsr_q}) : rem_sh[FP_W-1:0];
      dvd_d  = {dvd_q[QW-2:0], 1'b0};
      quot_d = {quot_q[QW-2:0], fits};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  assign busy   = busy_q;
  assign done_c = busy_q && (cnt_q == CW'(1));
  assign quot   = quot_q;

endmodule

// File: rtl/ray_setup_unit.sv
// Ray setup: registers a ray and computes inv_dir = 2^(2*FP_FRAC)/dir per
// component with one shared serial divider (x, y, z in turn), fixed latency.
// Optional macro RAY_SETUP_ZERO_INF_EN: zero dir component yields +max
// instead of 0.
module ray_setup_unit
  import rt_pkg::*;
#(
  parameter int unsigned FP_W    = RT_FP_W,
  parameter int unsigned FP_FRAC = RT_FP_FRAC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  vec3_t           in_origin,
  input  vec3_t           in_dir,
  input  logic [FP_W-1:0] in_t_min,
  input  logic [FP_W-1:0] in_t_max,
  output logic            out_valid,
  input  logic            out_ready,
  output ray_t            out_ray
);

  localparam logic [FP_W-1:0] SAT_MAG = {1'b0, {(FP_W-1){1'b1}}};
`ifdef RAY_SETUP_ZERO_INF_EN
  localparam logic [FP_W-1:0] ZERO_VAL = SAT_MAG;
`else
  localparam logic [FP_W-1:0] ZERO_VAL = '0;
`endif

  setup_state_e state_q, state_d;
  logic [1:0]   comp_q, comp_d;
  ray_t         ray_q, ray_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic            div_start_c;
  logic [FP_W-1:0] div_divisor_c;
  logic            div_busy;
  logic            div_done_c;
  logic [FP_W:0]   div_quot;

  logic [FP_W-1:0] fin_d_c;
  logic [FP_W-1:0] fin_mag_c;
  logic [FP_W-1:0] fin_val_c;

  fxp_recip_div #(
    .FP_W    (FP_W),
    .FP_FRAC (FP_FRAC)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start_c),
    .divisor (div_divisor_c),
    .busy    (div_busy),
    .done_c  (div_done_c),
    .quot    (div_quot)
  );

  // FSM, ray and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      comp_q      <= '0;
      ray_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_q      <= comp_d;
      ray_q       <= ray_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Finalize: sign, saturate, zero-divisor substitution for the current component.
  always_comb begin
    fin_d_c   = vec_comp(ray_q.dir, comp_q);
    fin_mag_c = (div_quot > {1'b0, SAT_MAG}) ? SAT_MAG : div_quot[FP_W-1:0];
    if (fin_d_c == '0)          fin_val_c = ZERO_VAL;
    else if (fin_d_c[FP_W-1])   fin_val_c = -fin_mag_c;
    else                        fin_val_c = fin_mag_c;
  end

  // Next-state, ray update and divider control.
  always_comb begin
    state_d       = state_q;
    comp_d        = comp_q;
    ray_d         = ray_q;
    div_start_c   = 1'b0;
    div_divisor_c = abs_u(vec_comp(ray_q.dir, comp_q + 2'd1));
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ray_d.origin  = in_origin;
          ray_d.dir     = in_dir;
          ray_d.inv_dir = '0;
          ray_d.t_min   = in_t_min;
          ray_d.t_max   = in_t_max;
          comp_d        = 2'd0;
          div_start_c   = 1'b1;
          div_divisor_c = abs_u(in_dir.x);
          state_d       = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_busy && div_done_c) state_d = ST_FIN;
      end
      ST_FIN: begin
        ray_d.inv_dir = vec_set(ray_q.inv_dir, comp_q, fin_val_c);
        if (comp_q == 2'd2) begin
          state_d = ST_OUT;
        end else begin
          comp_d      = comp_q + 2'd1;
          div_start_c = 1'b1;
          state_d     = ST_DIV;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ray   = ray_q;

endmodule

// File: tb/tb_ray_setup_unit.sv
// Self-checking bench for ray_setup_unit: behavioural reference model with a
// per-cycle compare process, directed literal cases and randomized rays.
module tb_ray_setup_unit;
  import rt_pkg::*;

  localparam int unsigned LAT   = 102;
  localparam int unsigned BOUND = 400;
  localparam int unsigned RAY_W = $bits(ray_t);
`ifdef RAY_SETUP_ZERO_INF_EN
  localparam logic [RT_FP_W-1:0] ZERO_EXP = 32'h7FFFFFFF;
`else
  localparam logic [RT_FP_W-1:0] ZERO_EXP = 32'h00000000;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  vec3_t              in_origin;
  vec3_t              in_dir;
  logic [RT_FP_W-1:0] in_t_min;
  logic [RT_FP_W-1:0] in_t_max;
  logic               out_valid;
  logic               out_ready;
  ray_t               out_ray;

  ray_setup_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_origin (in_origin),
    .in_dir    (in_dir),
    .in_t_min  (in_t_min),
    .in_t_max  (in_t_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ray   (out_ray)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned n = 0;
  int unsigned acc_edge = 0;
  int unsigned acc_cnt = 0;
  int unsigned hs_cnt = 0;
  int unsigned last_lat = 0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_ready = 1'b1;
  bit          prev_dut_valid = 1'b0;
  ray_t        m_ray;
  ray_t        last_ray;

  task automatic check(input string name, input logic [RAY_W-1:0] act,
                       input logic [RAY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", name, BOUND);
  endtask

  function automatic vec3_t mkv(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    mkv.x = x;
    mkv.y = y;
    mkv.z = z;
  endfunction

  // Reciprocal by plain 64-bit arithmetic: sign(d) * min(2^32 / |d|, 2^31-1).
  function automatic logic [RT_FP_W-1:0] ref_inv(input logic [RT_FP_W-1:0] d);
    longint sd, ad, q;
    sd = longint'($signed(d));
    if (sd == 0) return ZERO_EXP;
    ad = (sd < 0) ? -sd : sd;
    q  = (longint'(1) << (2 * RT_FP_FRAC)) / ad;
    if (q > 64'sh7FFFFFFF) q = 64'sh7FFFFFFF;
    if (sd < 0) q = -q;
    return q[RT_FP_W-1:0];
  endfunction

  function automatic ray_t ref_ray(input vec3_t o, input vec3_t d,
                                   input logic [RT_FP_W-1:0] tmin, input logic [RT_FP_W-1:0] tmax);
    ref_ray.origin  = o;
    ref_ray.dir     = d;
    ref_ray.inv_dir = mkv(ref_inv(d.x), ref_inv(d.y), ref_inv(d.z));
    ref_ray.t_min   = tmin;
    ref_ray.t_max   = tmax;
  endfunction

  function automatic logic [31:0] rnd_comp();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h00000000;
      1:       v = 32'h00000001;
      2:       v = 32'hFFFFFFFF;
      3:       v = 32'h80000000;
      4:       v = 32'($urandom_range(1, 32'h0003FFFF));
      5:       v = -32'($urandom_range(1, 32'h0003FFFF));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Model and compare: inputs are stable across the preceding rising edge.
  always @(negedge clk) begin
    n++;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_ready = 1'b1;
      check("rst_out_valid", RAY_W'(out_valid), '0);
      check("rst_in_ready", RAY_W'(in_ready), RAY_W'(1));
      check("rst_out_ray", out_ray, '0);
    end else begin
      if (m_valid && out_ready) begin
        m_busy = 1'b0;
        hs_cnt++;
      end else if (m_ready && in_valid) begin
        m_busy   = 1'b1;
        acc_edge = n;
        m_ray    = ref_ray(in_origin, in_dir, in_t_min, in_t_max);
        acc_cnt++;
      end
      m_valid = m_busy && ((n - acc_edge) >= LAT);
      m_ready = !m_busy;
      check("out_valid", RAY_W'(out_valid), RAY_W'(m_valid));
      check("in_ready", RAY_W'(in_ready), RAY_W'(m_ready));
      if (m_valid) check("out_ray", out_ray, m_ray);
      if (out_valid) last_ray = out_ray;
      if (out_valid && !prev_dut_valid) last_lat = n - acc_edge;
    end
    prev_dut_valid = out_valid;
  end

  task automatic wait_acc(input int unsigned a0);
    for (int k = 0; k < BOUND && acc_cnt == a0; k++) begin
      @(negedge clk); #1;
    end
    if (acc_cnt == a0) timeout_fail("accept_wait");
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready high; 1: random out_ready and ignored in_valid; 2: stall 5 cycles.
  task automatic send(input vec3_t o, input vec3_t d, input logic [31:0] tmin,
                      input logic [31:0] tmax, input int mode);
    int unsigned a0, h0, stall;
    a0 = acc_cnt;
    h0 = hs_cnt;
    stall = 0;
    out_ready = (mode != 2);
    in_origin = o; in_dir = d; in_t_min = tmin; in_t_max = tmax;
    in_valid  = 1'b1;
    wait_acc(a0);
    for (int k = 0; k < BOUND && hs_cnt == h0; k++) begin
      if (mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = 1'($urandom_range(0, 1));
        in_dir    = mkv($urandom(), $urandom(), $urandom());
        in_origin = mkv($urandom(), $urandom(), $urandom());
      end else if (mode == 2) begin
        if (out_valid) stall++;
        out_ready = (stall > 5);
      end
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    if (hs_cnt == h0) timeout_fail("handshake_wait");
  endtask

  initial begin
    vec3_t o, d;
    int unsigned a0, h0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_origin = '0; in_dir = '0; in_t_min = '0; in_t_max = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Unit z direction; zero components for x and y.
    send(mkv(32'h00018000, 32'hFFFE0000, 32'h00030000), mkv(32'h0, 32'h0, 32'h00010000),
         32'h00000000, 32'h00640000, 0);
    check("lit26_inv", RAY_W'(last_ray.inv_dir), RAY_W'(mkv(ZERO_EXP, ZERO_EXP, 32'h00010000)));
    check("lit26_origin", RAY_W'(last_ray.origin), RAY_W'(mkv(32'h00018000, 32'hFFFE0000, 32'h00030000)));
    check("lit26_tmax", RAY_W'(last_ray.t_max), RAY_W'(32'h00640000));
    check("lit26_lat", RAY_W'(last_lat), RAY_W'(32'd102));

    // Mixed signs and powers of two, with a 5-cycle output stall.
    send(mkv(32'h1, 32'h2, 32'h3), mkv(32'h00020000, 32'hFFFF0000, 32'h00004000),
         32'h00001000, 32'h00200000, 2);
    check("lit27_inv", RAY_W'(last_ray.inv_dir), RAY_W'(mkv(32'h00008000, 32'hFFFF0000, 32'h00040000)));

    // Saturation and most-negative divisor.
    send(mkv(32'h0, 32'h0, 32'h0), mkv(32'h00000001, 32'hFFFFFFFF, 32'h80000000),
         32'h0, 32'hFFFFFFFF, 0);
    check("lit28_inv", RAY_W'(last_ray.inv_dir), RAY_W'(mkv(32'h7FFFFFFF, 32'h80000001, 32'hFFFFFFFE)));
    check("lit28_lat", RAY_W'(last_lat), RAY_W'(32'd102));

    // Zero x component.
    send(mkv(32'h5, 32'h6, 32'h7), mkv(32'h0, 32'h00010000, 32'hFFFF0000), 32'h0, 32'h1, 0);
    check("lit31_inv", RAY_W'(last_ray.inv_dir), RAY_W'(mkv(ZERO_EXP, 32'h00010000, 32'hFFFF0000)));

    // Reset 40 cycles into a request: that ray must never appear.
    a0 = acc_cnt;
    in_origin = mkv(32'h9, 32'h9, 32'h9); in_dir = mkv(32'h00030000, 32'h00050000, 32'h00070000);
    in_t_min = 32'h0; in_t_max = 32'h00010000; out_ready = 1'b1;
    in_valid = 1'b1;
    wait_acc(a0);
    for (int k = 0; k < BOUND && (n - acc_edge) < 40; k++) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    h0 = hs_cnt;
    repeat (LAT + 10) @(negedge clk);
    #1;
    check("rst_discard", RAY_W'(hs_cnt), RAY_W'(h0));
    send(mkv(32'h1, 32'h1, 32'h1), mkv(32'h00020000, 32'hFFFF0000, 32'h00004000), 32'h0, 32'h2, 0);
    check("post_rst_inv", RAY_W'(last_ray.inv_dir), RAY_W'(mkv(32'h00008000, 32'hFFFF0000, 32'h00040000)));
    check("post_rst_lat", RAY_W'(last_lat), RAY_W'(32'd102));

    // Randomized rays with random backpressure and ignored requests while busy.
    for (int i = 0; i < 25; i++) begin
      o = mkv($urandom(), $urandom(), $urandom());
      d = mkv(rnd_comp(), rnd_comp(), rnd_comp());
      send(o, d, $urandom(), $urandom(), (i % 3 == 2) ? 2 : 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/ray_setup_unit.md
RAY_SETUP_UNIT -- requirements
Module: ray_setup_unit

Interface
REQ-001 SHALL have parameters: FP_W, default 32, fixed-point word width; FP_FRAC, default 16, fractional bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_origin, input, vec3_t, ray origin (Q FP_W.FP_FRAC signed).
REQ-007 SHALL have port in_dir, input, vec3_t, ray direction.
REQ-008 SHALL have ports in_t_min and in_t_max, input, FP_W each, ray interval.
REQ-009 SHALL have port out_valid, output, 1, out_ray valid.
REQ-010 SHALL have port out_ready, input, 1, consumer (ray_box_unit req side) ready.
REQ-011 SHALL have port out_ray, output, ray_t, origin/dir/t_min/t_max passed through, inv_dir computed.

Function
REQ-012 SHALL register origin, dir, t_min, t_max on the accept edge and present them unchanged on out_ray.
REQ-013 SHALL compute each inv_dir component as sign(d) * floor(2^(2*FP_FRAC) / |d|), truncation toward zero; |d| formed as FP_W-bit unsigned so d = 0x80000000 is legal.
REQ-014 SHALL saturate a magnitude above 2^(FP_W-1)-1 to +0x7FFFFFFF (d>0) or -0x7FFFFFFF = 0x80000001 (d<0).
REQ-015 SHALL produce inv_dir component = 0 for d = 0 (macro off).
REQ-016 SHALL use a serial restoring divider: FP_W+1 quotient bits, one per cycle, plus one finalize cycle (sign, saturate) per component, components in order x, y, z.
REQ-017 SHALL use FSM states IDLE -> DIV -> FIN -> (next component DIV | OUT after z) -> IDLE on out handshake.
REQ-018 SHALL have fixed latency: accept on edge k -> out_valid first high in cycle k + 3*(FP_W+2) (102 for FP_W=32), including zero components.
REQ-019 SHALL assert in_ready only in IDLE; no overlap of requests (one ray in flight).
REQ-020 SHALL keep out_valid and out_ray stable while out_valid && !out_ready; return to IDLE on the handshake edge, with in_ready high the next cycle.
REQ-021 SHALL not depend on out_ready before out_valid; in_valid without in_ready is ignored.

Reset
REQ-022 SHALL force FSM to IDLE on rst_n low, asynchronously: in_ready=1 after release, out_valid=0, out_ray=0, divider state cleared; an in-flight ray is discarded.

Configuration
REQ-023 SHALL, with RAY_SETUP_ZERO_INF_EN defined, output 0x7FFFFFFF for a zero component; otherwise 0 (REQ-015). Latency is unchanged either way.

Structure
REQ-024 SHALL take FP_W/FP_FRAC defaults, vec3_t, ray_t, aabb_t from shared package rt_pkg, also used by ray_box_unit.
REQ-025 SHALL instantiate one sub-module fxp_recip_div (start/busy/done serial unsigned reciprocal, FP_W+1 cycles), reused per component.

Verification
REQ-026 SHALL cover: dir (0,0,1.0) accepted at edge k -> out_valid at k+102, inv_dir = (0,0,0x00010000), origin/t passed through.
REQ-027 SHALL cover: dir (2.0,-1.0,0.25) -> inv_dir = (0x00008000, 0xFFFF0000, 0x00040000).
REQ-028 SHALL cover: dir x raw 0x00000001, y raw 0xFFFFFFFF, z 0x80000000 -> (0x7FFFFFFF, 0x80000001, 0xFFFFFFFE).
REQ-029 SHALL cover: out_ready low 5 cycles after out_valid -> out_ray stable and in_ready=0 throughout; handshake, then in_ready=1 next cycle.
REQ-030 SHALL cover: rst_n pulsed low at cycle 40 of a request -> out_valid never rises for it; next request gives the correct result with latency 102.
REQ-031 SHALL cover: zero dir component with and without RAY_SETUP_ZERO_INF_EN -> 0x7FFFFFFF vs 0.
